// File: rtl/i2c_reg_seq.sv
`timescale 1ns/1ps
// Register-access sequencer for a Wishbone I2C master core: one request becomes
// a full byte write or a write-address/repeated-start/read-byte transfer on the slave.
module i2c_reg_seq #(
   parameter logic [15:0] PRESCALE = 16'd99,
   parameter logic [11:0] POLL_MAX = 12'd4095
) (
   input  logic       wb_clk_i,
   input  logic       arst_i,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rnw,
   input  logic [6:0] req_dev,
   input  logic [7:0] req_reg,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_err,
   output logic [2:0] m_adr_o,
   output logic [7:0] m_dat_o,
   input  logic [7:0] m_dat_i,
   output logic       m_we_o,
   output logic       m_stb_o,
   output logic       m_cyc_o,
   input  logic       m_ack_i
);
   localparam logic [2:0] ADR_TXR = 3'd3;
   localparam logic [2:0] ADR_CR  = 3'd4;
   localparam int SR_RXACK = 7, SR_BUSY = 6, SR_AL = 5, SR_TIP = 1, CR_WR = 4;
   localparam logic [1:0] ERR_OK = 2'b00, ERR_NACK = 2'b01, ERR_AL = 2'b10, ERR_TOUT = 2'b11;

   typedef enum logic [3:0] {
      INIT, IDLE, STEP_TXR, STEP_CR, POLL, RD_RXR, ABORT, ABORT_POLL, DONE
   } state_t;

   state_t      state, state_n;
   logic [1:0]  init_idx, init_idx_n, step, step_n, err_pend, err_pend_n, rsp_err_n;
   logic        rnw, rnw_n;
   logic [6:0]  dev, dev_n;
   logic [7:0]  reg_idx, reg_idx_n, wdata, wdata_n, rsp_rdata_n;
   logic [11:0] poll_cnt, poll_cnt_n, poll_inc;
   logic        cyc, cyc_n, we, we_n;
   logic [2:0]  adr, adr_n;
   logic [7:0]  dat, dat_n;
   logic [7:0]  txr_val, cr_val, init_val;
   logic        last_step, ack;
   logic        acc_req, acc_we;
   logic [2:0]  acc_adr;
   logic [7:0]  acc_dat;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign m_cyc_o   = cyc;
   assign m_stb_o   = cyc;
   assign m_we_o    = we;
   assign m_adr_o   = adr;
   assign m_dat_o   = dat;
   assign poll_inc  = poll_cnt + 12'd1;
   assign ack       = cyc && m_ack_i;

   // Per-step TXR/CR values; read step 3 is the receive command and has no TXR load.
   always_comb begin
      txr_val   = 8'h00;
      cr_val    = 8'h68;
      init_val  = 8'h80;
      last_step = rnw ? (step == 2'd3) : (step == 2'd2);
      case (step)
         2'd0: begin txr_val = {dev, 1'b0}; cr_val = 8'h90; end
         2'd1: begin txr_val = reg_idx;     cr_val = 8'h10; end
         2'd2: begin
            txr_val = rnw ? {dev, 1'b1} : wdata;
            cr_val  = rnw ? 8'h90 : 8'h50;
         end
         default: ;
      endcase
      case (init_idx)
         2'd0:    init_val = PRESCALE[7:0];
         2'd1:    init_val = PRESCALE[15:8];
         default: init_val = 8'h80;
      endcase
   end

   // Bus access wanted by the current state.
   always_comb begin
      acc_req = 1'b1;
      acc_we  = 1'b0;
      acc_adr = ADR_CR;
      acc_dat = 8'h00;
      case (state)
         INIT:     begin acc_we = 1'b1; acc_adr = {1'b0, init_idx}; acc_dat = init_val; end
         STEP_TXR: begin acc_we = 1'b1; acc_adr = ADR_TXR; acc_dat = txr_val; end
         STEP_CR:  begin acc_we = 1'b1; acc_dat = cr_val; end
         RD_RXR:   acc_adr = ADR_TXR;
         ABORT:    begin acc_we = 1'b1; acc_dat = 8'h40; end
         POLL, ABORT_POLL: begin end
         default:  acc_req = 1'b0;
      endcase
   end

   always_comb begin
      state_n     = state;
      init_idx_n  = init_idx;
      step_n      = step;
      err_pend_n  = err_pend;
      rsp_err_n   = rsp_err;
      rsp_rdata_n = rsp_rdata;
      rnw_n       = rnw;
      dev_n       = dev;
      reg_idx_n   = reg_idx;
      wdata_n     = wdata;
      poll_cnt_n  = poll_cnt;
      cyc_n       = cyc;
      we_n        = we;
      adr_n       = adr;
      dat_n       = dat;

      // A new access launches only from a cycle with cyc low, giving the idle gap after each ack.
      if (cyc) begin
         if (m_ack_i) cyc_n = 1'b0;
      end else if (acc_req) begin
         cyc_n = 1'b1;
         we_n  = acc_we;
         adr_n = acc_adr;
         dat_n = acc_dat;
      end

      case (state)
         INIT: if (ack) begin
            if (init_idx == 2'd2) begin
               init_idx_n = 2'd0;
               state_n    = IDLE;
            end else begin
               init_idx_n = init_idx + 2'd1;
            end
         end
         IDLE: if (req_valid) begin
            rnw_n     = req_rnw;
            dev_n     = req_dev;
            reg_idx_n = req_reg;
            wdata_n   = req_wdata;
            step_n    = 2'd0;
            state_n   = STEP_TXR;
         end
         STEP_TXR: if (ack) state_n = STEP_CR;
         STEP_CR: if (ack) begin
            poll_cnt_n = 12'd0;
            state_n    = POLL;
         end
         POLL: if (ack) begin
            poll_cnt_n = poll_inc;
            if (!m_dat_i[SR_TIP]) begin
               if (m_dat_i[SR_AL]) begin
                  rsp_err_n = ERR_AL;
                  state_n   = DONE;
               end else if (m_dat_i[SR_RXACK] && cr_val[CR_WR]) begin
                  err_pend_n = ERR_NACK;
                  state_n    = ABORT;
               end else if (last_step) begin
                  if (rnw) begin
                     state_n = RD_RXR;
                  end else begin
                     rsp_err_n = ERR_OK;
                     state_n   = DONE;
                  end
               end else begin
                  step_n  = step + 2'd1;
                  state_n = (rnw && step == 2'd2) ? STEP_CR : STEP_TXR;
               end
            end else if (poll_inc >= POLL_MAX) begin
               err_pend_n = ERR_TOUT;
               state_n    = ABORT;
            end
         end
         RD_RXR: if (ack) begin
            rsp_rdata_n = m_dat_i;
            rsp_err_n   = ERR_OK;
            state_n     = DONE;
         end
         ABORT: if (ack) state_n = ABORT_POLL;
         ABORT_POLL: if (ack && !m_dat_i[SR_BUSY]) begin
            rsp_err_n = err_pend;
            state_n   = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = INIT;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state     <= INIT;
         init_idx  <= 2'd0;
         step      <= 2'd0;
         err_pend  <= ERR_OK;
         rsp_err   <= ERR_OK;
         rsp_rdata <= 8'h00;
         rnw       <= 1'b0;
         dev       <= 7'h00;
         reg_idx   <= 8'h00;
         wdata     <= 8'h00;
         poll_cnt  <= 12'd0;
         cyc       <= 1'b0;
         we        <= 1'b0;
         adr       <= 3'd0;
         dat       <= 8'h00;
      end else begin
         state     <= state_n;
         init_idx  <= init_idx_n;
         step      <= step_n;
         err_pend  <= err_pend_n;
         rsp_err   <= rsp_err_n;
         rsp_rdata <= rsp_rdata_n;
         rnw       <= rnw_n;
         dev       <= dev_n;
         reg_idx   <= reg_idx_n;
         wdata     <= wdata_n;
         poll_cnt  <= poll_cnt_n;
         cyc       <= cyc_n;
         we        <= we_n;
         adr       <= adr_n;
         dat       <= dat_n;
      end
   end
endmodule

// File: tb/tb_i2c_reg_seq.sv
`timescale 1ns/1ps
// Bench for i2c_reg_seq: scripted I2C master register model, write-sequence and
// response scoreboards fed by a transaction-level reference model.
module tb_i2c_reg_seq;
   localparam logic [15:0] PRESC = 16'd99;
   localparam int          PMAX  = 4;

   logic       wb_clk_i = 1'b0, arst_i = 1'b0;
   logic       req_valid = 1'b0, req_rnw = 1'b0;
   logic [6:0] req_dev = 7'h00;
   logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
   logic       req_ready, rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic [2:0] m_adr_o;
   logic [7:0] m_dat_o;
   logic [7:0] m_dat_i = 8'h00;
   logic       m_we_o, m_stb_o, m_cyc_o;
   logic       m_ack_i = 1'b0;

   i2c_reg_seq #(.PRESCALE(PRESC), .POLL_MAX(12'(PMAX))) dut (
      .wb_clk_i(wb_clk_i), .arst_i(arst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
      .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i)
   );

   initial forever #5 wb_clk_i = ~wb_clk_i;

   typedef struct { logic [2:0] adr; logic [7:0] dat; } wr_t;
   typedef struct { logic [1:0] err; logic [7:0] rdata; bit abort; } rs_t;

   wr_t        wq[$];
   rs_t        rq[$];
   int         total = 0, bad = 0;
   logic [7:0] model_rdata = 8'h00;

   // scenario knobs read by the master model
   int         sc_fault = 0, sc_step = 0;
   bit         sc_rnw = 1'b0;
   logic [7:0] sc_rx = 8'h00;
   int         cmd_idx = 0, cur_cmd = 0, mode = 0, tip_left = 0, busy_left = 0, sr_reads = 0;
   bit         tout_active = 1'b0, busy_cleared = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic abort_run(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic expect_init();
      wq.push_back('{adr: 3'd0, dat: PRESC[7:0]});
      wq.push_back('{adr: 3'd1, dat: PRESC[15:8]});
      wq.push_back('{adr: 3'd2, dat: 8'h80});
   endtask

   // fault: 0 none, 1 NACK, 2 arbitration lost, 3 timeout; fstep = CR command index it hits
   task automatic expect_txn(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                             input logic [7:0] wd, input int fault, input int fstep,
                             input logic [7:0] rx);
      logic [7:0] txr [4];
      logic [7:0] cr [4];
      int  n;
      rs_t r;
      txr[0] = {dev, 1'b0}; txr[1] = rg; txr[2] = rnw ? {dev, 1'b1} : wd; txr[3] = 8'h00;
      cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = rnw ? 8'h90 : 8'h50; cr[3] = 8'h68;
      n = rnw ? 4 : 3;
      for (int k = 0; k < n; k++) begin
         if (k < 3) wq.push_back('{adr: 3'd3, dat: txr[k]});
         wq.push_back('{adr: 3'd4, dat: cr[k]});
         if (fault != 0 && k == fstep) break;
      end
      if (fault == 1 || fault == 3) wq.push_back('{adr: 3'd4, dat: 8'h40});
      if (fault == 0 && rnw) model_rdata = rx;
      r.err   = fault[1:0];
      r.rdata = model_rdata;
      r.abort = (fault == 1 || fault == 3);
      rq.push_back(r);
   endtask

   task automatic send(input bit rnw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input int fault, input int fstep,
                       input logic [7:0] rx);
      int n = 0;
      while (!req_ready && n < 3000) begin @(posedge wb_clk_i); #2; n++; end
      if (!req_ready) abort_run("ready_timeout");
      sc_fault = fault; sc_step = fstep; sc_rx = rx; sc_rnw = rnw;
      cmd_idx = 0; tout_active = 1'b0; busy_cleared = 1'b0;
      expect_txn(rnw, dev, rg, wd, fault, fstep, rx);
      req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
      @(posedge wb_clk_i); #2;
      req_valid = 1'b0;
      chk("ready_drop", req_ready, 1'b0);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (rq.size() != 0 && n < 3000) begin @(posedge wb_clk_i); #2; n++; end
      if (rq.size() != 0) abort_run("rsp_timeout");
      @(posedge wb_clk_i); #2;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 500) begin @(posedge wb_clk_i); #2; n++; end
      if (!req_ready) abort_run("init_timeout");
      chk("init_writes_left", wq.size(), 0);
   endtask

   // I2C master register model with random wait states
   initial begin : master
      int         ph, wait_left;
      logic [2:0] c_adr;
      logic [7:0] c_dat, sr;
      logic       c_we;
      wr_t        w;
      ph = 0; wait_left = 0; c_adr = 0; c_dat = 0; c_we = 0;
      forever begin
         @(negedge wb_clk_i);
         if (!arst_i) begin
            m_ack_i = 1'b0; ph = 0;
         end else if (m_ack_i) begin
            m_ack_i = 1'b0;
            chk("bus_gap", m_cyc_o | m_stb_o, 1'b0);
         end else if (m_cyc_o && m_stb_o) begin
            if (ph == 0) begin
               c_adr = m_adr_o; c_dat = m_dat_o; c_we = m_we_o;
               wait_left = $urandom_range(0, 2); ph = 1;
            end else begin
               chk("bus_stable", {m_adr_o, m_dat_o, m_we_o}, {c_adr, c_dat, c_we});
            end
            if (wait_left > 0) begin
               wait_left--;
            end else begin
               ph = 0;
               m_dat_i = 8'h00;
               if (c_we) begin
                  if (wq.size() == 0) begin
                     total++; bad++;
                     $display("FAIL wr_extra: got adr=%0d dat=%0h want none", c_adr, c_dat);
                  end else begin
                     w = wq.pop_front();
                     chk("wr_seq", {c_adr, c_dat}, {w.adr, w.dat});
                  end
                  if (c_adr == 3'd4) begin
                     if (tout_active) chk("tout_polls", sr_reads, PMAX);
                     tout_active = 1'b0;
                     sr_reads = 0;
                     if (c_dat == 8'h40) begin
                        mode = 4; busy_left = $urandom_range(0, 6);
                     end else begin
                        cur_cmd = cmd_idx;
                        mode = (sc_fault != 0 && cmd_idx == sc_step) ? sc_fault : 0;
                        tip_left = $urandom_range(0, 3);
                        if (mode == 3) tout_active = 1'b1;
                        cmd_idx++;
                     end
                  end
               end else if (c_adr == 3'd4) begin
                  sr_reads++;
                  if (mode == 4) begin
                     if (busy_left > 0) begin sr = 8'h40; busy_left--; end
                     else begin sr = 8'h00; busy_cleared = 1'b1; end
                  end else if (mode == 3 || tip_left > 0) begin
                     sr = 8'h42;
                     if (tip_left > 0) tip_left--;
                  end else if (mode == 1) sr = 8'h80;
                  else if (mode == 2) sr = 8'h20;
                  // receive command reports the master's own NACK in RxACK
                  else sr = (sc_rnw && cur_cmd == 3) ? 8'hC0 : 8'h40;
                  m_dat_i = sr;
               end else if (c_adr == 3'd3) begin
                  m_dat_i = sc_rx;
               end
               m_ack_i = 1'b1;
            end
         end
      end
   end

   initial begin : rsp_mon
      rs_t e;
      forever begin
         @(negedge wb_clk_i);
         if (arst_i && rsp_valid) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp_extra: got err=%0d want no response", rsp_err);
            end else begin
               e = rq.pop_front();
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_rdata", rsp_rdata, e.rdata);
               if (e.abort) chk("stop_busy_wait", busy_cleared, 1'b1);
            end
            @(negedge wb_clk_i);
            chk("rsp_pulse", rsp_valid, 1'b0);
            chk("idle_after", req_ready, 1'b1);
         end
      end
   end

   initial begin : watchdog
      #900000;
      abort_run("global_timeout");
   end

   initial begin : stim
      int n, f, fault, fstep, nst;
      bit rnw;
      #23;
      chk("rst_ready", req_ready, 1'b0);
      chk("rst_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 8'h00);
      chk("rst_err", rsp_err, 2'b00);
      chk("rst_bus", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o}, 14'h0);
      expect_init();
      @(posedge wb_clk_i); #2;
      arst_i = 1'b1;
      wait_ready();

      send(1'b0, 7'h50, 8'h12, 8'hA5, 0, 0, 8'h00); wait_rsp();
      send(1'b1, 7'h50, 8'h34, 8'h00, 0, 0, 8'h5C); wait_rsp();
      send(1'b0, 7'h50, 8'h12, 8'h33, 1, 0, 8'h00); wait_rsp();
      send(1'b1, 7'h50, 8'h34, 8'h00, 2, 1, 8'h77); wait_rsp();
      send(1'b0, 7'h21, 8'h40, 8'h99, 3, 2, 8'h00); wait_rsp();
      send(1'b1, 7'h7F, 8'hFF, 8'h00, 3, 3, 8'h11); wait_rsp();
      send(1'b1, 7'h0A, 8'h01, 8'h00, 1, 2, 8'h22); wait_rsp();
      send(1'b1, 7'h00, 8'h00, 8'h00, 0, 0, 8'hC3); wait_rsp();

      for (int i = 0; i < 40; i++) begin
         rnw = 1'($urandom_range(0, 1));
         nst = rnw ? 4 : 3;
         f = $urandom_range(0, 5);
         fault = (f > 3) ? 0 : f;
         fstep = (fault == 1) ? $urandom_range(0, 2) : $urandom_range(0, nst - 1);
         send(rnw, 7'($urandom), 8'($urandom), 8'($urandom), fault, fstep, 8'($urandom));
         wait_rsp();
      end

      // reset in the middle of a read while a bus cycle is open
      send(1'b1, 7'h50, 8'h34, 8'h00, 0, 0, 8'hE7);
      n = 0;
      while (!(cmd_idx >= 2 && m_cyc_o) && n < 500) begin @(posedge wb_clk_i); #2; n++; end
      if (!(cmd_idx >= 2 && m_cyc_o)) abort_run("midread_wait");
      arst_i = 1'b0;
      #1;
      chk("rst_mid_cyc", {m_cyc_o, m_stb_o}, 2'b00);
      chk("rst_mid_ready", req_ready, 1'b0);
      chk("rst_mid_rdata", rsp_rdata, 8'h00);
      wq.delete();
      rq.delete();
      model_rdata = 8'h00;
      repeat (3) @(posedge wb_clk_i);
      #2;
      expect_init();
      arst_i = 1'b1;
      wait_ready();

      send(1'b0, 7'h33, 8'h08, 8'h5A, 0, 0, 8'h00); wait_rsp();
      send(1'b1, 7'h33, 8'h08, 8'h00, 0, 0, 8'h4B); wait_rsp();

      chk("wr_left", wq.size(), 0);
      chk("rsp_left", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_reg_seq.md
I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clock wb_clk_i, reset arst_i (all state clears while arst_i=0, independent of wb_clk_i).
REQ-002 Parameters SHALL be: PRESCALE, 16'd99, value loaded into PRERlo/PRERhi; POLL_MAX, 12'd4095, maximum SR polls per step before timeout.
REQ-003 Ports SHALL be:
  wb_clk_i  in  1  clock
  arst_i  in  1  async reset, active low
  req_valid  in  1  transaction request
  req_ready  out  1  sequencer idle and accepting a request
  req_rnw  in  1  1=register read, 0=register write
  req_dev  in  7  I2C slave address
  req_reg  in  8  slave register index
  req_wdata  in  8  write data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_rdata  out  8  read data (valid with rsp_valid, read only)
  rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost, 11 timeout
  m_adr_o  out  3  master register address
  m_dat_o  out  8  master write data
  m_dat_i  in  8  master read data
  m_we_o  out  1  write enable
  m_stb_o  out  1  strobe
  m_cyc_o  out  1  cycle
  m_ack_i  in  1  master acknowledge

Function
REQ-004 Master register map SHALL be: 0 PRERlo, 1 PRERhi, 2 CTR (bit7 EN), 3 TXR(w)/RXR(r), 4 CR(w)/SR(r); CR bits STA7 STO6 RD5 WR4 ACK3 IACK0; SR bits RxACK7 BUSY6 AL5 TIP1.
REQ-005 Each bus access SHALL assert m_cyc_o=m_stb_o=1 with stable adr/dat/we until the cycle m_ack_i=1, then deassert both for at least one cycle; one access outstanding at a time; no timeout on m_ack_i.
REQ-006 After reset the FSM SHALL enter INIT and write PRERlo=PRESCALE[7:0], PRERhi=PRESCALE[15:8], CTR=8'h80, in that order, then go to IDLE.
REQ-007 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle req_valid&&req_ready, latching req_rnw/dev/reg/wdata; req_ready drops the next cycle.
REQ-008 Write transaction steps SHALL be: (TXR={dev,0}, CR=8'h90), (TXR=reg, CR=8'h10), (TXR=wdata, CR=8'h50).
REQ-009 Read transaction steps SHALL be: (TXR={dev,0}, CR=8'h90), (TXR=reg, CR=8'h10), (TXR={dev,1}, CR=8'h90, repeated start), (CR=8'h68, read with NACK and STOP), then one read of RXR captured into rsp_rdata.
REQ-010 After each CR write the FSM SHALL enter POLL: read SR repeatedly until TIP=0, counting polls; the first SR read occurs after the CR access completes.
REQ-011 On TIP=0: if AL=1, terminate with rsp_err=10 and issue no STOP; else if RxACK=1 on a write-type step (WR set), go to ABORT with rsp_err=01; else advance to the next step.
REQ-012 If POLL_MAX polls complete with TIP=1, the FSM SHALL go to ABORT with rsp_err=11.
REQ-013 ABORT SHALL write CR=8'h40 (STOP only), then poll SR until BUSY=0 (no poll limit), then complete.
REQ-014 Completion SHALL pulse rsp_valid for exactly one cycle with rsp_err (and rsp_rdata for successful reads) held until the next completion; the FSM returns to IDLE the following cycle.
REQ-015 rsp_rdata SHALL be unchanged by write transactions and by failed reads.
REQ-016 The FSM states SHALL be INIT, IDLE, STEP_TXR, STEP_CR, POLL, RD_RXR, ABORT, ABORT_POLL, DONE; no other state is reachable.

Reset
REQ-017 While arst_i=0: req_ready=0, rsp_valid=0, rsp_rdata=8'h00, rsp_err=2'b00, m_cyc_o=m_stb_o=m_we_o=0, m_adr_o=3'd0, m_dat_o=8'h00, poll counter=0, state=INIT.
REQ-018 Reset asserted mid-transaction SHALL abandon the bus cycle immediately with no response pulse; after release INIT reruns in full.

Verification
REQ-019 Release reset -> writes adr0=8'h63, adr1=8'h00, adr2=8'h80 in order, then req_ready=1.
REQ-020 Write dev=7'h50, reg=8'h12, wdata=8'hA5, slave ACKs all -> TXR/CR pairs (A0,90),(12,10),(A5,50); rsp_valid with rsp_err=00.
REQ-021 Read dev=7'h50, reg=8'h34, RXR returns 8'h5C -> CR sequence 90,10,90(TXR=A1),68; rsp_rdata=8'h5C, rsp_err=00.
REQ-022 Address NACK (SR=8'h80 after first step) -> CR=8'h40 written, BUSY polled to 0, rsp_err=01, no further TXR writes.
REQ-023 SR=8'h20 (AL) after second step -> rsp_err=10 with no CR=8'h40 write; TIP stuck 1 with POLL_MAX=4 -> exactly 4 SR reads, then STOP, rsp_err=11.
REQ-024 arst_i pulsed low while m_cyc_o=1 mid-read -> m_cyc_o=0 immediately, no rsp_valid, INIT sequence repeats.
